io_alu_bus_unit: RTL and testbench

- Combinational ALU datapath slice for the multi-cycle CPU. Contains the ALU control decoder, the 32-bit ALU and the memory-mapped IO bus.
- The IO bus steers stores to data memory or VGA text memory, and returns register write-back data from memory, keyboard FIFO, character count or random source.
- Generates the CPU stall (`pause`) for keyboard reads.
- The only state is the random-table address counter and a registered read strobe.

---
 rtl/io_alu_bus_unit.sv | 199 +++++++++++++++++++
 tb/tb_io_alu_bus_unit.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_alu_bus_unit.sv
// io_alu_bus_unit: ALU control decoder, DATA_W-bit ALU and the memory-mapped
// IO bus for the multi-cycle CPU. The ALU and the bus are purely
// combinational. The only state is the random-table address counter and the
// registered strobe that tells the random source a value was consumed.
module io_alu_bus_unit #(
  parameter int DATA_W = 32,
  parameter int RAN_AW = 7
) (
  input  logic              clk_1s,
  input  logic              rst_out,
  input  logic [1:0]        ALUop,
  input  logic [5:0]        funct,
  input  logic [DATA_W-1:0] ALUop1,
  input  logic [DATA_W-1:0] ALUop2,
  output logic [2:0]        ALUsignal,
  output logic              zero,
  output logic [DATA_W-1:0] ALUresult,
  input  logic [5:0]        action,
  input  logic              IRWrite,
  input  logic [DATA_W-1:0] mem_addr,
  input  logic              MemWrite,
  input  logic [DATA_W-1:0] Rdata2,
  input  logic [DATA_W-1:0] result_or_data,
  input  logic [7:0]        ASCII,
  input  logic              fifo_ready,
  input  logic [12:0]       char_cnt,
  input  logic [1:0]        Ran_num,
  output logic              Mem_we,
  output logic              VGA_we,
  output logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] reg_data,
  output logic              pause,
  output logic              read_Ran,
  output logic [RAN_AW-1:0] Ran_addr
);

  // Shift amount width for SRL; only the low bits of operand A matter.
  localparam int SH_W = $clog2(DATA_W);

  // Opcode of the word load instruction.
  localparam logic [5:0] OP_LW = 6'b100011;

  // R-type function codes understood by the decoder.
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_SRL = 6'b000010;

  // Byte offsets inside the IO register region (address bits below the region nibble).
  localparam logic [DATA_W-5:0] OFF_KBD = '0;
  localparam logic [DATA_W-5:0] OFF_CNT = (DATA_W-4)'(4);

  // ALU function encoding shared by the decoder output and the ALU.
  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_XOR = 3'b011,
    ALU_NOR = 3'b100,
    ALU_SRL = 3'b101,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } aluFn_t;

  // Bus regions selected by the top address nibble.
  typedef enum logic [2:0] {
    RGN_DMEM,
    RGN_VGA,
    RGN_IO,
    RGN_RAND,
    RGN_NONE
  } region_t;

  aluFn_t              w_aluFn;
  logic [DATA_W-1:0]   w_aluResult;
  logic                w_slt;
  region_t             w_region;
  logic [DATA_W-5:0]   w_offset;
  logic                w_isKbd;
  logic                w_isCnt;
  logic                w_isLoad;
  logic                w_pause;
  logic                w_ranLoad;
  logic [DATA_W-1:0]   w_regData;
  logic                r_readRan;
  logic [RAN_AW-1:0]   r_ranAddr;

  // ALU control: fixed operations for loads/stores, branches and ORI; R-type decodes funct.
  always_comb begin
    w_aluFn = ALU_ADD;
    case (ALUop)
      2'b00: w_aluFn = ALU_ADD;
      2'b01: w_aluFn = ALU_SUB;
      2'b11: w_aluFn = ALU_OR;
      2'b10: begin
        case (funct)
          FN_ADD:  w_aluFn = ALU_ADD;
          FN_SUB:  w_aluFn = ALU_SUB;
          FN_AND:  w_aluFn = ALU_AND;
          FN_OR:   w_aluFn = ALU_OR;
          FN_XOR:  w_aluFn = ALU_XOR;
          FN_NOR:  w_aluFn = ALU_NOR;
          FN_SLT:  w_aluFn = ALU_SLT;
          FN_SRL:  w_aluFn = ALU_SRL;
          default: w_aluFn = ALU_ADD;
        endcase
      end
      default: w_aluFn = ALU_ADD;
    endcase
  end

  assign ALUsignal = w_aluFn;

  // Signed less-than for SLT; ADD/SUB simply wrap with no overflow flag.
  assign w_slt = ($signed(ALUop1) < $signed(ALUop2));

  // ALU datapath: SRL shifts operand B by the low bits of operand A, zero filling.
  always_comb begin
    w_aluResult = '0;
    case (w_aluFn)
      ALU_AND: w_aluResult = ALUop1 & ALUop2;
      ALU_OR:  w_aluResult = ALUop1 | ALUop2;
      ALU_ADD: w_aluResult = ALUop1 + ALUop2;
      ALU_XOR: w_aluResult = ALUop1 ^ ALUop2;
      ALU_NOR: w_aluResult = ~(ALUop1 | ALUop2);
      ALU_SRL: w_aluResult = ALUop2 >> ALUop1[SH_W-1:0];
      ALU_SUB: w_aluResult = ALUop1 - ALUop2;
      ALU_SLT: w_aluResult = {{(DATA_W-1){1'b0}}, w_slt};
      default: w_aluResult = '0;
    endcase
  end

  assign ALUresult = w_aluResult;
  assign zero      = (w_aluResult == '0);

  // Address decode: 0x0-0xB data memory, 0xC VGA, 0xD IO registers, 0xE random, 0xF unmapped.
  always_comb begin
    w_region = RGN_DMEM;
    case (mem_addr[DATA_W-1:DATA_W-4])
      4'hC:    w_region = RGN_VGA;
      4'hD:    w_region = RGN_IO;
      4'hE:    w_region = RGN_RAND;
      4'hF:    w_region = RGN_NONE;
      default: w_region = RGN_DMEM;
    endcase
  end

  assign w_offset = mem_addr[DATA_W-5:0];
  assign w_isKbd  = (w_region == RGN_IO) && (w_offset == OFF_KBD);
  assign w_isCnt  = (w_region == RGN_IO) && (w_offset == OFF_CNT);
  assign w_isLoad = (action == OP_LW);

  // Stores only reach memory or VGA; writes into IO, random or unmapped space are dropped.
  assign Mem_we     = MemWrite && (w_region == RGN_DMEM);
  assign VGA_we     = MemWrite && (w_region == RGN_VGA);
  assign write_data = Rdata2;

  // A keyboard load with an empty FIFO stalls the CPU, except during fetch.
  assign w_pause = w_isLoad && w_isKbd && !fifo_ready && !IRWrite;
  assign pause   = w_pause;

  // A load from the random region consumes one table entry per cycle it is held.
  assign w_ranLoad = w_isLoad && (w_region == RGN_RAND) && !w_pause;

  // Write-back mux: IO and random sources override the memory/ALU value.
  always_comb begin
    w_regData = result_or_data;
    if (w_isKbd) begin
      w_regData = {{(DATA_W-8){1'b0}}, ASCII};
    end else if (w_isCnt) begin
      w_regData = {{(DATA_W-13){1'b0}}, char_cnt};
    end else if (w_region == RGN_RAND) begin
      w_regData = {{(DATA_W-2){1'b0}}, Ran_num};
    end
  end

  assign reg_data = w_regData;

  // Random-table counter and consume strobe; reset cancels any increment in flight.
  always_ff @(posedge clk_1s or negedge rst_out) begin
    if (!rst_out) begin
      r_readRan <= 1'b0;
      r_ranAddr <= '0;
    end else begin
      r_readRan <= w_ranLoad;
      if (w_ranLoad) begin
        r_ranAddr <= r_ranAddr + RAN_AW'(1);
      end
    end
  end

  assign read_Ran = r_readRan;
  assign Ran_addr = r_ranAddr;

endmodule

// File: tb/tb_io_alu_bus_unit.sv
// tb_io_alu_bus_unit: table-driven and randomized checks of io_alu_bus_unit
// against a behavioural model of the ALU, the IO bus and the random counter.
module tb_io_alu_bus_unit;

  localparam logic [5:0] LW = 6'b100011;
  localparam logic [5:0] SW = 6'b101011;

  logic        clk_1s;
  logic        rst_out;
  logic [1:0]  ALUop;
  logic [5:0]  funct;
  logic [31:0] ALUop1;
  logic [31:0] ALUop2;
  logic [2:0]  ALUsignal;
  logic        zero;
  logic [31:0] ALUresult;
  logic [5:0]  action;
  logic        IRWrite;
  logic [31:0] mem_addr;
  logic        MemWrite;
  logic [31:0] Rdata2;
  logic [31:0] result_or_data;
  logic [7:0]  ASCII;
  logic        fifo_ready;
  logic [12:0] char_cnt;
  logic [1:0]  Ran_num;
  logic        Mem_we;
  logic        VGA_we;
  logic [31:0] write_data;
  logic [31:0] reg_data;
  logic        pause;
  logic        read_Ran;
  logic [6:0]  Ran_addr;

  int total;
  int bad;
  int modelAddr;

  typedef struct packed {
    logic [1:0]  op;
    logic [5:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  sig;
    logic [31:0] res;
    logic        z;
  } aluVec_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        mw;
    logic [5:0]  act;
    logic        fr;
    logic        ir;
    logic        memWe;
    logic        vgaWe;
    logic        pz;
    logic [31:0] regData;
  } busVec_t;

  typedef struct packed {
    logic        memWe;
    logic        vgaWe;
    logic        pz;
    logic [31:0] regData;
    logic [31:0] writeData;
  } busExp_t;

  aluVec_t aluTab[14];
  busVec_t busTab[13];

  io_alu_bus_unit dut (
    .clk_1s(clk_1s), .rst_out(rst_out),
    .ALUop(ALUop), .funct(funct), .ALUop1(ALUop1), .ALUop2(ALUop2),
    .ALUsignal(ALUsignal), .zero(zero), .ALUresult(ALUresult),
    .action(action), .IRWrite(IRWrite), .mem_addr(mem_addr),
    .MemWrite(MemWrite), .Rdata2(Rdata2), .result_or_data(result_or_data),
    .ASCII(ASCII), .fifo_ready(fifo_ready), .char_cnt(char_cnt),
    .Ran_num(Ran_num), .Mem_we(Mem_we), .VGA_we(VGA_we),
    .write_data(write_data), .reg_data(reg_data), .pause(pause),
    .read_Ran(read_Ran), .Ran_addr(Ran_addr)
  );

  // Free-running clock.
  initial clk_1s = 1'b0;
  always #5 clk_1s = ~clk_1s;

  // Hard time limit so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  // Decoder model: which operation the spec names for each ALUop/funct pair.
  function automatic logic [2:0] modelSig(input logic [1:0] op, input logic [5:0] fn);
    if (op == 2'b00) return 3'b010;
    if (op == 2'b01) return 3'b110;
    if (op == 2'b11) return 3'b001;
    case (fn)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b100110: return 3'b011;
      6'b100111: return 3'b100;
      6'b101010: return 3'b111;
      6'b000010: return 3'b101;
      default:   return 3'b010;
    endcase
  endfunction

  // ALU model using plain integer arithmetic.
  function automatic logic [31:0] modelRes(input logic [2:0] sig, input logic [31:0] a, input logic [31:0] b);
    int sa;
    int sb;
    sa = a;
    sb = b;
    case (sig)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b011:  return a ^ b;
      3'b100:  return ~(a | b);
      3'b101:  return b >> (a % 32);
      3'b110:  return a - b;
      default: return (sa < sb) ? 32'd1 : 32'd0;
    endcase
  endfunction

  // Bus model computed from the current bench-driven inputs.
  function automatic busExp_t modelBus();
    busExp_t e;
    int rgn;
    logic [27:0] off;
    rgn = int'(mem_addr[31:28]);
    off = mem_addr[27:0];
    e.memWe = MemWrite && (rgn <= 11);
    e.vgaWe = MemWrite && (rgn == 12);
    e.writeData = Rdata2;
    e.pz = (action == LW) && (rgn == 13) && (off == 0) && !fifo_ready && !IRWrite;
    if (rgn == 13 && off == 0)      e.regData = {24'b0, ASCII};
    else if (rgn == 13 && off == 4) e.regData = {19'b0, char_cnt};
    else if (rgn == 14)             e.regData = {30'b0, Ran_num};
    else                            e.regData = result_or_data;
    return e;
  endfunction

  task automatic applyStimulus(input busVec_t v);
    mem_addr   = v.addr;
    MemWrite   = v.mw;
    action     = v.act;
    fifo_ready = v.fr;
    IRWrite    = v.ir;
  endtask

  task automatic checkComb();
    busExp_t e;
    logic [2:0]  s;
    logic [31:0] r;
    e = modelBus();
    s = modelSig(ALUop, funct);
    r = modelRes(s, ALUop1, ALUop2);
    checkOutput("rnd_ALUsignal", ALUsignal, s);
    checkOutput("rnd_ALUresult", ALUresult, r);
    checkOutput("rnd_zero", zero, r == 0);
    checkOutput("rnd_Mem_we", Mem_we, e.memWe);
    checkOutput("rnd_VGA_we", VGA_we, e.vgaWe);
    checkOutput("rnd_write_data", write_data, e.writeData);
    checkOutput("rnd_reg_data", reg_data, e.regData);
    checkOutput("rnd_pause", pause, e.pz);
  endtask

  // One clock edge, then compare the random strobe and counter with the model.
  task automatic clockAndCheck();
    busExp_t e;
    logic expLoad;
    e = modelBus();
    expLoad = (action == LW) && (mem_addr[31:28] == 4'hE) && !e.pz;
    @(posedge clk_1s);
    #1;
    if (expLoad) modelAddr = (modelAddr + 1) % 128;
    checkOutput("read_Ran", read_Ran, expLoad);
    checkOutput("Ran_addr", Ran_addr, modelAddr[6:0]);
  endtask

  initial begin
    total = 0;
    bad = 0;
    modelAddr = 0;

    aluTab[0]  = '{2'b10, 6'b100010, 32'd5, 32'd7, 3'b110, 32'hFFFFFFFE, 1'b0};
    aluTab[1]  = '{2'b10, 6'b100010, 32'd9, 32'd9, 3'b110, 32'h0, 1'b1};
    aluTab[2]  = '{2'b10, 6'b101010, 32'hFFFFFFFF, 32'd1, 3'b111, 32'd1, 1'b0};
    aluTab[3]  = '{2'b10, 6'b000010, 32'd4, 32'h80, 3'b101, 32'h8, 1'b0};
    aluTab[4]  = '{2'b00, 6'b000000, 32'd3, 32'd4, 3'b010, 32'd7, 1'b0};
    aluTab[5]  = '{2'b01, 6'b100000, 32'd10, 32'd3, 3'b110, 32'd7, 1'b0};
    aluTab[6]  = '{2'b11, 6'b100010, 32'hF0, 32'h0F, 3'b001, 32'hFF, 1'b0};
    aluTab[7]  = '{2'b10, 6'b100100, 32'hFF00, 32'h0FF0, 3'b000, 32'h0F00, 1'b0};
    aluTab[8]  = '{2'b10, 6'b100101, 32'd1, 32'd2, 3'b001, 32'd3, 1'b0};
    aluTab[9]  = '{2'b10, 6'b100110, 32'hFF, 32'h0F, 3'b011, 32'hF0, 1'b0};
    aluTab[10] = '{2'b10, 6'b100111, 32'h0, 32'h0, 3'b100, 32'hFFFFFFFF, 1'b0};
    aluTab[11] = '{2'b10, 6'b111111, 32'hFFFFFFFF, 32'd1, 3'b010, 32'h0, 1'b1};
    aluTab[12] = '{2'b10, 6'b101010, 32'd1, 32'hFFFFFFFF, 3'b111, 32'h0, 1'b1};
    aluTab[13] = '{2'b10, 6'b000010, 32'h24, 32'h80, 3'b101, 32'h8, 1'b0};

    busTab[0]  = '{32'h00000010, 1'b1, SW, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h12345678};
    busTab[1]  = '{32'hC0000004, 1'b1, SW, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h12345678};
    busTab[2]  = '{32'hD0000000, 1'b1, SW, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00000061};
    busTab[3]  = '{32'hE0000000, 1'b1, SW, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00000002};
    busTab[4]  = '{32'hF0000000, 1'b1, SW, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h12345678};
    busTab[5]  = '{32'hB0000000, 1'b1, SW, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h12345678};
    busTab[6]  = '{32'hD0000000, 1'b0, LW, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h00000061};
    busTab[7]  = '{32'hD0000000, 1'b0, LW, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00000061};
    busTab[8]  = '{32'hD0000000, 1'b0, LW, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h00000061};
    busTab[9]  = '{32'hD0000004, 1'b0, LW, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00001ABC};
    busTab[10] = '{32'hD0000000, 1'b0, 6'b000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00000061};
    busTab[11] = '{32'hD0000000, 1'b1, LW, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h00000061};
    busTab[12] = '{32'h00000010, 1'b1, LW, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h12345678};

    rst_out = 1'b0;
    ALUop = 2'b00; funct = 6'b0; ALUop1 = '0; ALUop2 = '0;
    action = 6'b0; IRWrite = 1'b0; mem_addr = '0; MemWrite = 1'b0;
    Rdata2 = 32'h41; result_or_data = 32'h12345678; ASCII = 8'h61;
    fifo_ready = 1'b0; char_cnt = 13'h1ABC; Ran_num = 2'b10;
    #1;
    checkOutput("reset_Ran_addr", Ran_addr, 7'd0);
    checkOutput("reset_read_Ran", read_Ran, 1'b0);
    @(negedge clk_1s);
    rst_out = 1'b1;

    for (int i = 0; i < 14; i++) begin
      @(negedge clk_1s);
      ALUop = aluTab[i].op; funct = aluTab[i].fn;
      ALUop1 = aluTab[i].a; ALUop2 = aluTab[i].b;
      #1;
      checkOutput($sformatf("alu%0d_sig", i), ALUsignal, aluTab[i].sig);
      checkOutput($sformatf("alu%0d_res", i), ALUresult, aluTab[i].res);
      checkOutput($sformatf("alu%0d_zero", i), zero, aluTab[i].z);
    end

    for (int i = 0; i < 13; i++) begin
      @(negedge clk_1s);
      applyStimulus(busTab[i]);
      #1;
      checkOutput($sformatf("bus%0d_Mem_we", i), Mem_we, busTab[i].memWe);
      checkOutput($sformatf("bus%0d_VGA_we", i), VGA_we, busTab[i].vgaWe);
      checkOutput($sformatf("bus%0d_pause", i), pause, busTab[i].pz);
      checkOutput($sformatf("bus%0d_reg_data", i), reg_data, busTab[i].regData);
      checkOutput($sformatf("bus%0d_write_data", i), write_data, 32'h41);
    end

    // Random load held for three cycles, then released.
    @(negedge clk_1s);
    MemWrite = 1'b0; IRWrite = 1'b0; action = LW; mem_addr = 32'hE0000000; Ran_num = 2'b10;
    #1;
    checkOutput("ran_reg_data", reg_data, 32'd2);
    checkOutput("ran_pause", pause, 1'b0);
    for (int i = 0; i < 3; i++) begin
      clockAndCheck();
      checkOutput("ran_hold_reg_data", reg_data, 32'd2);
    end
    checkOutput("ran_addr_after3", Ran_addr, 7'd3);
    @(negedge clk_1s);
    action = 6'b0;
    clockAndCheck();

    // Count up to 127 and wrap back to 0.
    @(negedge clk_1s);
    action = LW;
    for (int i = 0; i < 124; i++) clockAndCheck();
    checkOutput("ran_addr_127", Ran_addr, 7'd127);
    clockAndCheck();
    checkOutput("ran_addr_wrap", Ran_addr, 7'd0);

    // Asynchronous reset in the middle of a held load.
    clockAndCheck();
    #2;
    rst_out = 1'b0;
    #1;
    modelAddr = 0;
    checkOutput("midreset_Ran_addr", Ran_addr, 7'd0);
    checkOutput("midreset_read_Ran", read_Ran, 1'b0);
    @(posedge clk_1s);
    #1;
    checkOutput("heldreset_Ran_addr", Ran_addr, 7'd0);
    checkOutput("heldreset_read_Ran", read_Ran, 1'b0);
    @(negedge clk_1s);
    rst_out = 1'b1;
    clockAndCheck();
    checkOutput("resume_Ran_addr", Ran_addr, 7'd1);
    @(negedge clk_1s);
    action = 6'b0;
    clockAndCheck();

    // Randomized traffic against the model.
    for (int i = 0; i < 300; i++) begin
      logic [27:0] offs [4];
      logic [5:0]  fns [8];
      offs[0] = 28'h0; offs[1] = 28'h4; offs[2] = 28'h8; offs[3] = 28'h40;
      fns[0] = 6'b100000; fns[1] = 6'b100010; fns[2] = 6'b100100; fns[3] = 6'b100101;
      fns[4] = 6'b100110; fns[5] = 6'b100111; fns[6] = 6'b101010; fns[7] = 6'b000010;
      @(negedge clk_1s);
      ALUop  = 2'($urandom_range(0, 3));
      funct  = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fns[$urandom_range(0, 7)];
      ALUop1 = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 40));
      ALUop2 = ($urandom_range(0, 3) == 0) ? ALUop1 : $urandom;
      mem_addr = {4'($urandom_range(0, 15)), offs[$urandom_range(0, 3)]};
      if ($urandom_range(0, 2) == 0) mem_addr[31:28] = 4'hE;
      MemWrite = 1'($urandom);
      action = ($urandom_range(0, 3) == 0) ? 6'($urandom) : (($urandom_range(0, 2) == 0) ? SW : LW);
      IRWrite = ($urandom_range(0, 3) == 0);
      fifo_ready = 1'($urandom);
      Rdata2 = $urandom; result_or_data = $urandom; ASCII = 8'($urandom);
      char_cnt = 13'($urandom); Ran_num = 2'($urandom);
      #1;
      checkComb();
      clockAndCheck();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
